// File: rtl/cceip_axi_mem_pkg.sv
// cceip_axi_mem_pkg: shared types for the BRAM-backed AXI4 responder.
// FSM state enums, beat counter type and byte-lane helper.
package cceip_axi_mem_pkg;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wr_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_t;

  typedef logic [7:0] beat_cnt_t;

  localparam int DEF_DATA_WIDTH = 64;
  localparam int BYTE_LSB = $clog2(DEF_DATA_WIDTH / 8);

  function automatic int byte_lsb(input int dw);
    return $clog2(dw / 8);
  endfunction

endpackage

// File: rtl/cceip_axi_mem_rd_skid.sv
// cceip_axi_mem_rd_skid: 2-entry {rlast,rdata} buffer for the R channel.
// Ports: in_valid/in_data push, out_valid/out_ready/out_data pop,
// count = occupancy used by the top to gate BRAM fetches.
module cceip_axi_mem_rd_skid #(
  parameter int W = 65
) (
  input  logic         ap_clk,
  input  logic         areset,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   count
);

  logic [W-1:0] e0;
  logic [W-1:0] e1;
  logic [1:0]   cnt;
  logic         pop;

  assign pop       = out_valid & out_ready;
  assign out_valid = (cnt != 2'd0);
  assign out_data  = e0;
  assign count     = cnt;

  // Pushes are only issued when a slot is free,
  // so push-when-full without pop never happens.
  always_ff @(posedge ap_clk) begin
    if (areset) begin
      cnt <= 2'd0;
    end else begin
      unique case ({in_valid, pop})
        2'b11: begin
          if (cnt == 2'd2) begin
            e0 <= e1;
            e1 <= in_data;
          end else begin
            e0 <= in_data;
          end
        end
        2'b10: begin
          if (cnt == 2'd0) e0 <= in_data;
          else             e1 <= in_data;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          e0  <= e1;
          cnt <= cnt - 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/cceip_axi_mem_responder.sv
// cceip_axi_mem_responder: AXI4 INCR-burst slave backed by inferred BRAM.
// Ports: ap_clk/areset (sync, active-high), AXI4 AW/W/B and AR/R subset,
// protocol_err (sticky wlast mismatch, only with CCEIP_AXI_MEM_LAST_CHECK_EN).
module cceip_axi_mem_responder
  import cceip_axi_mem_pkg::*;
#(
  parameter int C_S_AXI_ADDR_WIDTH = 64,
  parameter int C_S_AXI_DATA_WIDTH = 64,
  parameter int C_MEM_DEPTH_LOG2   = 10
) (
  input  logic                            ap_clk,
  input  logic                            areset,
  input  logic                            s_axi_awvalid,
  output logic                            s_axi_awready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]                      s_axi_awlen,
  input  logic                            s_axi_wvalid,
  output logic                            s_axi_wready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                            s_axi_wlast,
  output logic                            s_axi_bvalid,
  input  logic                            s_axi_bready,
  input  logic                            s_axi_arvalid,
  output logic                            s_axi_arready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]                      s_axi_arlen,
  output logic                            s_axi_rvalid,
  input  logic                            s_axi_rready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic                            s_axi_rlast,
  output logic                            protocol_err
);

  localparam int DW    = C_S_AXI_DATA_WIDTH;
  localparam int AW    = C_S_AXI_ADDR_WIDTH;
  localparam int LSB   = byte_lsb(DW);
  localparam int DL    = C_MEM_DEPTH_LOG2;
  localparam int NB    = DW / 8;
  localparam int DEPTH = 1 << DL;

  typedef logic [DL-1:0] idx_t;

  logic [DW-1:0] mem [DEPTH];

  // ---------------- write channel ----------------
  wr_state_t wstate;
  idx_t      widx;
  beat_cnt_t wcnt;
  logic      aw_hs;
  logic      w_hs;

  assign s_axi_awready = !areset && (wstate == W_IDLE);
  assign s_axi_wready  = !areset && (wstate == W_DATA);
  assign s_axi_bvalid  = !areset && (wstate == W_RESP);
  assign aw_hs = s_axi_awvalid & s_axi_awready;
  assign w_hs  = s_axi_wvalid & s_axi_wready;

  // Burst length comes from awlen alone; wlast never ends it.
  always_ff @(posedge ap_clk) begin
    if (areset) begin
      wstate <= W_IDLE;
      widx   <= '0;
      wcnt   <= '0;
    end else begin
      unique case (wstate)
        W_IDLE: begin
          if (aw_hs) begin
            widx   <= s_axi_awaddr[DL+LSB-1:LSB];
            wcnt   <= s_axi_awlen;
            wstate <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_hs) begin
            widx <= widx + idx_t'(1);
            wcnt <= wcnt - 8'd1;
            if (wcnt == 8'd0) wstate <= W_RESP;
          end
        end
        W_RESP: begin
          if (s_axi_bready) wstate <= W_IDLE;
        end
        default: wstate <= W_IDLE;
      endcase
    end
  end

  // ---------------- read channel ----------------
  rd_state_t     rstate;
  idx_t          ridx;
  beat_cnt_t     fleft;
  logic          pend;
  logic          pend_last;
  logic [DW-1:0] rd_q;
  logic          ar_hs;
  logic          f_en;
  logic          f_last;
  idx_t          f_idx;
  logic [2:0]    occ;
  logic          sk_valid;
  logic [DW:0]   sk_data;
  logic [1:0]    sk_cnt;
  logic          sk_pop;

  assign s_axi_arready = !areset && (rstate == R_IDLE);
  assign ar_hs  = s_axi_arvalid & s_axi_arready;
  assign sk_pop = s_axi_rvalid & s_axi_rready;

  // Slots still claimed at the end of this cycle, counting the
  // fetch already in the BRAM pipe and the beat leaving now.
  assign occ = {1'b0, sk_cnt} + {2'b0, pend} - {2'b0, sk_pop};

  // First fetch rides on the AR handshake itself so rvalid
  // appears two cycles after it.
  always_comb begin
    f_en   = 1'b0;
    f_idx  = ridx;
    f_last = (fleft == 8'd1);
    if (ar_hs) begin
      f_en   = 1'b1;
      f_idx  = s_axi_araddr[DL+LSB-1:LSB];
      f_last = (s_axi_arlen == 8'd0);
    end else if (rstate == R_DATA && fleft != 8'd0 && occ < 3'd2) begin
      f_en = 1'b1;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (areset) begin
      rstate    <= R_IDLE;
      ridx      <= '0;
      fleft     <= '0;
      pend      <= 1'b0;
      pend_last <= 1'b0;
    end else begin
      pend      <= f_en;
      pend_last <= f_last;
      if (f_en) ridx <= f_idx + idx_t'(1);
      unique case (rstate)
        R_IDLE: begin
          if (ar_hs) begin
            fleft  <= s_axi_arlen;
            rstate <= R_DATA;
          end
        end
        R_DATA: begin
          if (f_en) fleft <= fleft - 8'd1;
          if (sk_pop && s_axi_rlast) rstate <= R_IDLE;
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

  // Single write port with byte enables, registered read port.
  // Nonblocking update gives read-first on a same-word collision.
  always_ff @(posedge ap_clk) begin
    if (w_hs) begin
      for (int b = 0; b < NB; b++) begin
        if (s_axi_wstrb[b]) mem[widx][8*b +: 8] <= s_axi_wdata[8*b +: 8];
      end
    end
    if (f_en) rd_q <= mem[f_idx];
  end

  cceip_axi_mem_rd_skid #(
    .W(DW + 1)
  ) u_skid (
    .ap_clk    (ap_clk),
    .areset    (areset),
    .in_valid  (pend),
    .in_data   ({pend_last, rd_q}),
    .out_valid (sk_valid),
    .out_ready (s_axi_rready),
    .out_data  (sk_data),
    .count     (sk_cnt)
  );

  assign s_axi_rvalid = !areset && sk_valid;
  assign s_axi_rdata  = areset ? '0 : sk_data[DW-1:0];
  assign s_axi_rlast  = !areset && sk_valid && sk_data[DW];

  logic unused_addr;
  assign unused_addr = ^{s_axi_awaddr[AW-1:DL+LSB], s_axi_awaddr[LSB-1:0],
                         s_axi_araddr[AW-1:DL+LSB], s_axi_araddr[LSB-1:0]};

`ifdef CCEIP_AXI_MEM_LAST_CHECK_EN
  logic perr;

  always_ff @(posedge ap_clk) begin
    if (areset) begin
      perr <= 1'b0;
    end else if (w_hs && (s_axi_wlast != (wcnt == 8'd0))) begin
      perr <= 1'b1;
    end
  end

  assign protocol_err = !areset && perr;
`else
  logic unused_wlast;
  assign unused_wlast = s_axi_wlast;
  assign protocol_err = 1'b0;
`endif

endmodule

// File: tb/tb_cceip_axi_mem_responder.sv
// tb_cceip_axi_mem_responder: scoreboard bench for the AXI BRAM responder.
// Bench-side memory model predicts every read beat.
module tb_cceip_axi_mem_responder;

  logic        ap_clk = 1'b0;
  logic        areset = 1'b1;
  logic        s_axi_awvalid = 1'b0;
  logic        s_axi_awready;
  logic [63:0] s_axi_awaddr = '0;
  logic [7:0]  s_axi_awlen = '0;
  logic        s_axi_wvalid = 1'b0;
  logic        s_axi_wready;
  logic [63:0] s_axi_wdata = '0;
  logic [7:0]  s_axi_wstrb = '0;
  logic        s_axi_wlast = 1'b0;
  logic        s_axi_bvalid;
  logic        s_axi_bready = 1'b0;
  logic        s_axi_arvalid = 1'b0;
  logic        s_axi_arready;
  logic [63:0] s_axi_araddr = '0;
  logic [7:0]  s_axi_arlen = '0;
  logic        s_axi_rvalid;
  logic        s_axi_rready = 1'b0;
  logic [63:0] s_axi_rdata;
  logic        s_axi_rlast;
  logic        protocol_err;

  cceip_axi_mem_responder dut (
    .ap_clk        (ap_clk),
    .areset        (areset),
    .s_axi_awvalid (s_axi_awvalid),
    .s_axi_awready (s_axi_awready),
    .s_axi_awaddr  (s_axi_awaddr),
    .s_axi_awlen   (s_axi_awlen),
    .s_axi_wvalid  (s_axi_wvalid),
    .s_axi_wready  (s_axi_wready),
    .s_axi_wdata   (s_axi_wdata),
    .s_axi_wstrb   (s_axi_wstrb),
    .s_axi_wlast   (s_axi_wlast),
    .s_axi_bvalid  (s_axi_bvalid),
    .s_axi_bready  (s_axi_bready),
    .s_axi_arvalid (s_axi_arvalid),
    .s_axi_arready (s_axi_arready),
    .s_axi_araddr  (s_axi_araddr),
    .s_axi_arlen   (s_axi_arlen),
    .s_axi_rvalid  (s_axi_rvalid),
    .s_axi_rready  (s_axi_rready),
    .s_axi_rdata   (s_axi_rdata),
    .s_axi_rlast   (s_axi_rlast),
    .protocol_err  (protocol_err)
  );

  always #5 ap_clk = ~ap_clk;

  int ntests = 0;
  int nfail  = 0;

  logic [63:0] model [1024];
  logic [63:0] wbuf  [256];
  logic [64:0] sbq   [$];

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic axi_write(input logic [63:0] addr, input int len,
                           input logic [7:0] strb, input int bad_beat,
                           input int bdelay);
    int t;
    int idx;
    idx = int'(addr[12:3]);
    s_axi_awaddr  = addr;
    s_axi_awlen   = len[7:0];
    s_axi_awvalid = 1'b1;
    t = 0;
    while (!s_axi_awready && t < 200) begin tick(); t++; end
    if (!s_axi_awready) begin
      ntests++; nfail++;
      $display("FAIL aw_timeout awready=%b want 1", s_axi_awready);
    end
    tick();
    s_axi_awvalid = 1'b0;
    for (int b = 0; b <= len; b++) begin
      s_axi_wvalid = 1'b1;
      s_axi_wdata  = wbuf[b];
      s_axi_wstrb  = strb;
      s_axi_wlast  = (b == len) || (b == bad_beat);
      t = 0;
      while (!s_axi_wready && t < 200) begin tick(); t++; end
      if (!s_axi_wready) begin
        ntests++; nfail++;
        $display("FAIL w_timeout beat=%0d wready=%b want 1", b, s_axi_wready);
      end
      tick();
      for (int k = 0; k < 8; k++)
        if (strb[k]) model[idx][8*k +: 8] = wbuf[b][8*k +: 8];
      idx = (idx + 1) % 1024;
    end
    s_axi_wvalid = 1'b0;
    s_axi_wlast  = 1'b0;
    for (int d = 0; d < bdelay; d++) begin
      ntests++;
      if (s_axi_bvalid !== 1'b1 || s_axi_awready !== 1'b0) begin
        nfail++;
        $display("FAIL b_hold cyc=%0d bvalid=%b awready=%b want 1 0",
                 d, s_axi_bvalid, s_axi_awready);
      end
      tick();
    end
    s_axi_bready = 1'b1;
    t = 0;
    while (!s_axi_bvalid && t < 200) begin tick(); t++; end
    ntests++;
    if (s_axi_bvalid !== 1'b1) begin
      nfail++;
      $display("FAIL bvalid got=%b want 1", s_axi_bvalid);
    end
    tick();
    s_axi_bready = 1'b0;
    ntests++;
    if (s_axi_bvalid !== 1'b0 || s_axi_awready !== 1'b1) begin
      nfail++;
      $display("FAIL b_done bvalid=%b awready=%b want 0 1",
               s_axi_bvalid, s_axi_awready);
    end
  endtask

  task automatic axi_read(input logic [63:0] addr, input int len,
                          input int pct, input bit chk_lat,
                          input int abort_at);
    int idx;
    int got;
    int t;
    int bubbles;
    bit started;
    bit stalled;
    logic [63:0] hd;
    logic hl;
    logic [64:0] exp;
    idx = int'(addr[12:3]);
    got = 0; bubbles = 0; started = 0; stalled = 0;
    hd = '0; hl = 1'b0;
    for (int b = 0; b <= len; b++)
      sbq.push_back({(b == len), model[(idx + b) % 1024]});
    s_axi_rready  = (pct == 100);
    s_axi_araddr  = addr;
    s_axi_arlen   = len[7:0];
    s_axi_arvalid = 1'b1;
    t = 0;
    while (!s_axi_arready && t < 200) begin tick(); t++; end
    if (!s_axi_arready) begin
      ntests++; nfail++;
      $display("FAIL ar_timeout arready=%b want 1", s_axi_arready);
    end
    tick();
    s_axi_arvalid = 1'b0;
    if (chk_lat) begin
      ntests++;
      if (s_axi_rvalid !== 1'b0) begin
        nfail++;
        $display("FAIL lat_early rvalid=%b want 0", s_axi_rvalid);
      end
      tick();
      ntests++;
      if (s_axi_rvalid !== 1'b1) begin
        nfail++;
        $display("FAIL lat_first rvalid=%b want 1", s_axi_rvalid);
      end
    end
    t = 0;
    while (got <= len && t < 3000) begin
      if (stalled) begin
        ntests++;
        if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== hd || s_axi_rlast !== hl) begin
          nfail++;
          $display("FAIL stall_stable rvalid=%b rdata=%h rlast=%b want 1 %h %b",
                   s_axi_rvalid, s_axi_rdata, s_axi_rlast, hd, hl);
        end
      end
      s_axi_rready = ($urandom_range(99) < pct);
      if (started && !s_axi_rvalid) bubbles++;
      if (s_axi_rvalid && s_axi_rready) begin
        exp = sbq.pop_front();
        ntests++;
        if ({s_axi_rlast, s_axi_rdata} !== exp) begin
          nfail++;
          $display("FAIL rbeat %0d got=%b_%h want=%b_%h", got,
                   s_axi_rlast, s_axi_rdata, exp[64], exp[63:0]);
        end
        got++;
        started = 1;
        stalled = 0;
      end else if (s_axi_rvalid) begin
        stalled = 1;
        started = 1;
        hd = s_axi_rdata;
        hl = s_axi_rlast;
      end else begin
        stalled = 0;
      end
      tick();
      t++;
      if (abort_at > 0 && got == abort_at) begin
        areset = 1'b1;
        s_axi_rready = 1'b0;
        tick();
        areset = 1'b0;
        #1;
        ntests++;
        if (s_axi_rvalid !== 1'b0 || s_axi_arready !== 1'b1) begin
          nfail++;
          $display("FAIL abort_reset rvalid=%b arready=%b want 0 1",
                   s_axi_rvalid, s_axi_arready);
        end
        tick();
        tick();
        ntests++;
        if (s_axi_rvalid !== 1'b0) begin
          nfail++;
          $display("FAIL abort_stray rvalid=%b want 0", s_axi_rvalid);
        end
        sbq.delete();
        return;
      end
    end
    s_axi_rready = 1'b0;
    ntests++;
    if (got <= len) begin
      nfail++;
      $display("FAIL read_timeout beats=%0d want %0d", got, len + 1);
    end
    if (pct == 100) begin
      ntests++;
      if (bubbles != 0) begin
        nfail++;
        $display("FAIL bubbles got=%0d want 0", bubbles);
      end
    end
    ntests++;
    if (sbq.size() != 0 || s_axi_arready !== 1'b1) begin
      nfail++;
      $display("FAIL read_end left=%0d arready=%b want 0 1",
               sbq.size(), s_axi_arready);
    end
    sbq.delete();
  endtask

  task automatic test_reset();
    areset = 1'b1;
    repeat (3) tick();
    ntests++;
    if ({s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready,
         s_axi_rvalid, s_axi_rlast, protocol_err} !== 7'b0 ||
        s_axi_rdata !== 64'h0) begin
      nfail++;
      $display("FAIL reset_outs aw=%b w=%b b=%b ar=%b r=%b l=%b pe=%b d=%h want 0",
               s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready,
               s_axi_rvalid, s_axi_rlast, protocol_err, s_axi_rdata);
    end
    areset = 1'b0;
    #1;
    ntests++;
    if (s_axi_awready !== 1'b1 || s_axi_arready !== 1'b1) begin
      nfail++;
      $display("FAIL reset_ready awready=%b arready=%b want 1 1",
               s_axi_awready, s_axi_arready);
    end
    tick();
  endtask

  task automatic test_single();
    wbuf[0] = 64'h1122334455667788;
    axi_write(64'h40, 0, 8'hFF, -1, 0);
    axi_read(64'h40, 0, 100, 1, -1);
    axi_read(64'hF000_0000_0000_0045, 0, 100, 1, -1);
  endtask

  task automatic test_burst16();
    for (int i = 0; i < 16; i++) wbuf[i] = 64'(i);
    axi_write(64'h0, 15, 8'hFF, -1, 0);
    axi_read(64'h0, 15, 100, 1, -1);
  endtask

  task automatic test_strobe();
    wbuf[0] = '1;
    axi_write(64'h100, 0, 8'hFF, -1, 0);
    wbuf[0] = '0;
    axi_write(64'h100, 0, 8'h0F, -1, 0);
    axi_read(64'h100, 0, 100, 0, -1);
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 4; i++) wbuf[i] = 64'hA0 + 64'(i);
    axi_write(64'h1FF0, 3, 8'hFF, -1, 0);
    axi_read(64'h0, 1, 100, 1, -1);
    axi_read(64'h1FF0, 3, 100, 1, -1);
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 8; i++) wbuf[i] = {$urandom, $urandom};
    axi_write(64'h400, 7, 8'hFF, -1, 5);
    axi_read(64'h400, 7, 50, 0, -1);
    axi_read(64'h400, 7, 30, 0, -1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 256; i++) wbuf[i] = {$urandom, $urandom};
    axi_write(64'h800, 255, 8'hFF, -1, 0);
    axi_read(64'h800, 255, 100, 1, -1);
    axi_read(64'h800, 255, 70, 0, -1);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 8; i++) wbuf[i] = 64'hC0DE_0000 + 64'(i);
    axi_write(64'h600, 7, 8'hFF, -1, 0);
    axi_read(64'h600, 7, 100, 1, 3);
    axi_read(64'h600, 1, 100, 1, -1);
  endtask

  task automatic test_last_check();
    logic want;
`ifdef CCEIP_AXI_MEM_LAST_CHECK_EN
    want = 1'b1;
`else
    want = 1'b0;
`endif
    for (int i = 0; i < 4; i++) wbuf[i] = 64'h5A00 + 64'(i);
    axi_write(64'h700, 3, 8'hFF, 1, 0);
    ntests++;
    if (protocol_err !== want) begin
      nfail++;
      $display("FAIL protocol_err got=%b want %b", protocol_err, want);
    end
    axi_read(64'h700, 3, 100, 1, -1);
    areset = 1'b1;
    tick();
    areset = 1'b0;
    #1;
    ntests++;
    if (protocol_err !== 1'b0) begin
      nfail++;
      $display("FAIL perr_clear got=%b want 0", protocol_err);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst16();
    test_strobe();
    test_wrap();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_last_check();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $display("[TB] %0d tests run, %0d failed", ntests, nfail + 1);
    $fatal(1, "watchdog");
  end

endmodule
